pitch_frame_fetch: RTL and testbench
====================================

# pitch_frame_fetch

Upstream frame-fetch stage for the pitch/time-stretch datapath. Reads a clip's 32-bit length header and stereo samples (`{left[31:16], right[15:0]}`) from SDRAM. Assembles successive analysis frames, each advanced by the analysis hop H_a, into a local frame buffer. Hands each frame to the windowing/OLA core through a valid/ack handshake.

## Interface
Parameters:
- `FRAME_SIZE`, default 1024: samples per analysis frame; must be a power of two.
- `HS`, default 256: synthesis hop in samples.
- `ADDR_W`, default 23: SDRAM word-address width.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_rst`, in, 1: reset; synchronous, active-high.
- `fetch_start`, in, 1: start pulse; latches `fetch_base` and `fetch_speed`.
- `fetch_base`, in, ADDR_W: SDRAM address of the header word.
- `fetch_speed`, in, 4: speed ratio in Q1.3 format (8 = 1.0).
- `fetch_length`, out, 32: header value, i.e. the sample count.
- `fetch_frame_valid`, out, 1: the frame buffer holds a complete frame.
- `fetch_frame_ack`, in, 1: the consumer has finished with the current frame.
- `fetch_last`, out, 1: qualifies `fetch_frame_valid`; the current frame is the final one.
- `fetch_done`, out, 1: one-cycle pulse when the clip is exhausted.
- `buf_raddr`, in, log2(FRAME_SIZE): frame-relative read index.
- `buf_rdata`, out, 32: registered read data.
- `sdram_read`, out, 1: read request.
- `sdram_addr`, out, ADDR_W: request address.
- `sdram_readdata`, in, 32: returned data.
- `sdram_finished`, in, 1: one-cycle completion strobe.

## Operation
- H_a = (HS × speed) >> 3, where speed = max(`fetch_speed`, 1). Width is 13 bits; the fraction is discarded.
- Address map:
  - Header word at base.
  - Sample k at base + 1 + k.
  - Frame f covers samples f·H_a … f·H_a + FRAME_SIZE − 1.
- State machine:
  - IDLE: on `fetch_start`, go to HDR.
  - HDR: read the header into `fetch_length`.
    - If length = 0, go to DONE.
    - Otherwise set f = 0 and go to FILL.
  - FILL: request each sample index in order.
    - Index < length: issue an SDRAM read and write the returned word into the buffer.
    - Index ≥ length: write zero into the buffer, one cycle per sample, with no SDRAM access.
    - After the last slot is written, go to READY.
  - READY: hold `fetch_frame_valid`.
    - On `fetch_frame_ack`: if `fetch_last`, go to DONE; else set f = f + 1 and go to FILL.
  - DONE: pulse `fetch_done` for one cycle, then go to IDLE.
- `fetch_last` = (f·H_a + FRAME_SIZE ≥ length). It is computed on entry to READY.
- `fetch_start` is ignored outside IDLE.
- `fetch_frame_ack` is ignored outside READY.

## Timing
- Reset: every output is 0 and the state is IDLE. All outputs are 0 one edge after `i_rst` is sampled high, including when reset lands mid-transfer; an outstanding SDRAM request is abandoned.
- SDRAM read handshake:
  - `sdram_read` is registered high, with `sdram_addr` stable, until `sdram_finished` is sampled high.
  - `sdram_readdata` is captured in that same cycle.
  - `sdram_read` is low for exactly one cycle before the next request.
  - Each SDRAM word therefore costs at least 3 cycles.
- Buffer write: on the `sdram_finished` cycle for a fetched sample; on each cycle for a zero-filled sample.
- `fetch_frame_valid` rises on the edge after the final buffer write.
- `fetch_frame_valid` falls on the edge after `fetch_frame_ack`.
- When ack coincides with `fetch_last`, `fetch_done` pulses on the cycle after valid falls.
- `buf_rdata` returns data for `buf_raddr` one cycle after the address is presented. Contents are stable only while `fetch_frame_valid` = 1.
- `fetch_length` holds its value from header capture until the next `fetch_start` or reset.

## Configuration
Macro: `PITCH_FETCH_OVERLAP_EN`.
- Defined:
  - The buffer is circular with a frame-base pointer.
  - When H_a < FRAME_SIZE, each new frame advances the pointer by H_a modulo FRAME_SIZE and fetches only the H_a new tail samples.
  - `buf_raddr` is offset by the pointer, so the consumer still sees index 0 as the first sample of the frame.
  - When H_a ≥ FRAME_SIZE, the whole frame is refetched.
- Undefined: every frame refetches all FRAME_SIZE slots and the pointer is tied to 0.

## Test plan
Bench parameters: FRAME_SIZE = 8, HS = 4. Sample k holds data {k, ~k}.
- Speed 8 (H_a = 4), length 20, acking each frame:
  - Four frames, starting at samples 0, 4, 8, 12.
  - `fetch_last` is set only on the 4th frame.
  - `fetch_done` pulses once.
  - 32 sample reads with the macro undefined; 8 + 4 + 4 + 4 = 20 with `PITCH_FETCH_OVERLAP_EN` defined.
- Speed 8, length 10:
  - Frame 0 holds samples 0–7.
  - Frame 1 holds samples 4–9 followed by two zero words.
  - No read is issued at addresses ≥ base + 11.
- Length 0: header read only; `fetch_done` pulses; `fetch_frame_valid` is never asserted.
- Speed 0: behaves as speed 1, so H_a = 0 after the shift; frames must still advance by clamping H_a to at least 1, which the bench checks as a 1-sample step.
- SDRAM model with a 5-cycle finish delay:
  - `sdram_addr` is stable while `sdram_read` is high.
  - One idle cycle between requests.
  - `fetch_start` pulsed mid-FILL is ignored.
- `i_rst` asserted during FILL: next cycle all outputs are 0 and the state is IDLE; a fresh `fetch_start` then re-reads the header at base.

Source files
------------

// File: rtl/pitch_frame_fetch.sv
// pitch_frame_fetch
//
// Frame-fetch stage for the pitch/time-stretch datapath. Reads a clip's
// 32-bit length header and its stereo samples {left, right} from SDRAM,
// builds analysis frames advanced by the analysis hop H_a into a local
// frame buffer, and hands each frame to the windowing/OLA core through a
// valid/ack handshake.
//
// Ports:
//   i_clk, i_rst           single clock, synchronous active-high reset
//   fetch_start            start pulse (IDLE only); latches base and speed
//   fetch_base, fetch_speed header address, Q1.3 speed ratio (8 = 1.0)
//   fetch_length           header value (sample count)
//   fetch_frame_valid      frame buffer holds a complete frame
//   fetch_frame_ack        consumer is done with the current frame
//   fetch_last             current frame is the final one
//   fetch_done             one-cycle pulse when the clip is exhausted
//   buf_raddr, buf_rdata   frame-relative read port, one cycle latency
//   sdram_*                read request / completion handshake
//
// Configuration macro: PITCH_FETCH_OVERLAP_EN
//   Defined   - circular buffer; consecutive overlapping frames fetch only
//               the H_a new tail samples.
//   Undefined - every frame refetches all FRAME_SIZE slots.

`timescale 1ns/1ps

module pitch_frame_fetch #(
    parameter int FRAME_SIZE = 1024,
    parameter int HS         = 256,
    parameter int ADDR_W     = 23
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          fetch_start,
    input  logic [ADDR_W-1:0]             fetch_base,
    input  logic [3:0]                    fetch_speed,
    output logic [31:0]                   fetch_length,
    output logic                          fetch_frame_valid,
    input  logic                          fetch_frame_ack,
    output logic                          fetch_last,
    output logic                          fetch_done,
    input  logic [$clog2(FRAME_SIZE)-1:0] buf_raddr,
    output logic [31:0]                   buf_rdata,
    output logic                          sdram_read,
    output logic [ADDR_W-1:0]             sdram_addr,
    input  logic [31:0]                   sdram_readdata,
    input  logic                          sdram_finished
);

    localparam int AW = $clog2(FRAME_SIZE);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FILL,
        S_READY,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [3:0]        speed_q;
    logic [31:0]       frame_start;
    logic [31:0]       samp_idx;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     fill_cnt;
    logic [AW-1:0]     base_ptr;
    logic [AW-1:0]     rd_index;
    logic [3:0]        speed_eff;
    logic [12:0]       ha_raw;
    logic [12:0]       ha;
    logic              buf_we;
    logic [31:0]       buf_wdata;
    logic [31:0]       frame_buf [FRAME_SIZE];

    // Speed 0 is treated as 1; a hop that shifts down to 0 is clamped to 1
    // so frames always advance.
    assign speed_eff = (speed_q == 4'd0) ? 4'd1 : speed_q;
    assign ha_raw    = 13'((32'(HS) * 32'(speed_eff)) >> 3);
    assign ha        = (ha_raw == 13'd0) ? 13'd1 : ha_raw;

    // A slot is written either when its SDRAM read completes or, past the
    // end of the clip, immediately with zero.
    assign buf_we    = (state == S_FILL) &&
                       (sdram_read ? sdram_finished : (samp_idx >= fetch_length));
    assign buf_wdata = sdram_read ? sdram_readdata : 32'd0;

`ifndef PITCH_FETCH_OVERLAP_EN
    assign base_ptr = '0;
`endif

    // Consumer index 0 is always the first sample of the current frame.
    assign rd_index = base_ptr + buf_raddr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state             <= S_IDLE;
            base_q            <= '0;
            speed_q           <= '0;
            frame_start       <= '0;
            samp_idx          <= '0;
            wr_ptr            <= '0;
            fill_cnt          <= '0;
            fetch_length      <= '0;
            fetch_frame_valid <= 1'b0;
            fetch_last        <= 1'b0;
            fetch_done        <= 1'b0;
            sdram_read        <= 1'b0;
            sdram_addr        <= '0;
`ifdef PITCH_FETCH_OVERLAP_EN
            base_ptr          <= '0;
`endif
        end else begin
            fetch_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fetch_start) begin
                        base_q       <= fetch_base;
                        speed_q      <= fetch_speed;
                        fetch_length <= '0;
                        sdram_read   <= 1'b1;
                        sdram_addr   <= fetch_base;
                        state        <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (sdram_finished) begin
                        sdram_read   <= 1'b0;
                        fetch_length <= sdram_readdata;
                        if (sdram_readdata == 32'd0) begin
                            fetch_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            frame_start <= '0;
                            samp_idx    <= '0;
                            wr_ptr      <= '0;
                            fill_cnt    <= CW'(FRAME_SIZE);
`ifdef PITCH_FETCH_OVERLAP_EN
                            base_ptr    <= '0;
`endif
                            state       <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (buf_we) begin
                        sdram_read <= 1'b0;
                        wr_ptr     <= wr_ptr + AW'(1);
                        samp_idx   <= samp_idx + 32'd1;
                        fill_cnt   <= fill_cnt - CW'(1);
                        if (fill_cnt == CW'(1)) begin
                            fetch_frame_valid <= 1'b1;
                            fetch_last <= (({1'b0, frame_start} + 33'(FRAME_SIZE)) >=
                                           {1'b0, fetch_length});
                            state <= S_READY;
                        end
                    end else if (!sdram_read) begin
                        // Reached only after a low cycle, which gives the
                        // mandatory one-cycle gap between requests.
                        sdram_read <= 1'b1;
                        sdram_addr <= base_q + ADDR_W'(1) + ADDR_W'(samp_idx);
                    end
                end
                S_READY: begin
                    if (fetch_frame_ack) begin
                        fetch_frame_valid <= 1'b0;
                        if (fetch_last) begin
                            fetch_last <= 1'b0;
                            fetch_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            frame_start <= frame_start + 32'(ha);
`ifdef PITCH_FETCH_OVERLAP_EN
                            if (32'(ha) < 32'(FRAME_SIZE)) begin
                                // The old head slots become the new tail.
                                base_ptr <= base_ptr + AW'(ha);
                                wr_ptr   <= base_ptr;
                                samp_idx <= frame_start + 32'(FRAME_SIZE);
                                fill_cnt <= CW'(ha);
                            end else begin
                                base_ptr <= '0;
                                wr_ptr   <= '0;
                                samp_idx <= frame_start + 32'(ha);
                                fill_cnt <= CW'(FRAME_SIZE);
                            end
`else
                            wr_ptr   <= '0;
                            samp_idx <= frame_start + 32'(ha);
                            fill_cnt <= CW'(FRAME_SIZE);
`endif
                            state <= S_FILL;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (buf_we) begin
            frame_buf[wr_ptr] <= buf_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            buf_rdata <= '0;
        end else begin
            buf_rdata <= frame_buf[rd_index];
        end
    end

endmodule

// File: tb/tb_pitch_frame_fetch.sv
// Testbench for pitch_frame_fetch (FRAME_SIZE = 8, HS = 4).
// Sample k of the clip holds {k, ~k}; the SDRAM model finishes each read
// after a programmable delay.

`timescale 1ns/1ps

module tb_pitch_frame_fetch;

    localparam int FRAME_SIZE = 8;
    localparam int HS         = 4;
    localparam int ADDR_W     = 16;
    localparam int AW         = 3;
    localparam logic [ADDR_W-1:0] BASE_A = 16'h0100;
    localparam logic [ADDR_W-1:0] BASE_B = 16'h0400;

    typedef struct packed {
        logic                      last;
        logic [FRAME_SIZE*32-1:0]  words;
    } frame_t;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              fetch_start;
    logic [ADDR_W-1:0] fetch_base;
    logic [3:0]        fetch_speed;
    logic [31:0]       fetch_length;
    logic              fetch_frame_valid;
    logic              fetch_frame_ack;
    logic              fetch_last;
    logic              fetch_done;
    logic [AW-1:0]     buf_raddr;
    logic [31:0]       buf_rdata;
    logic              sdram_read;
    logic [ADDR_W-1:0] sdram_addr;
    logic [31:0]       sdram_readdata;
    logic              sdram_finished;

    int total = 0;
    int bad   = 0;

    frame_t exp_q[$];

    int                lat = 2;
    logic [31:0]       clip_len = 32'd0;
    logic [ADDR_W-1:0] cur_base = '0;
    int                rd_cnt = 0;
    int                hdr_cnt = 0;
    int                frames_seen = 0;
    int                done_cnt = 0;
    bit                first_seen = 1'b0;
    logic [ADDR_W-1:0] first_addr = '0;
    logic [ADDR_W-1:0] max_addr = '0;

    pitch_frame_fetch #(
        .FRAME_SIZE(FRAME_SIZE),
        .HS(HS),
        .ADDR_W(ADDR_W)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .fetch_start(fetch_start),
        .fetch_base(fetch_base),
        .fetch_speed(fetch_speed),
        .fetch_length(fetch_length),
        .fetch_frame_valid(fetch_frame_valid),
        .fetch_frame_ack(fetch_frame_ack),
        .fetch_last(fetch_last),
        .fetch_done(fetch_done),
        .buf_raddr(buf_raddr),
        .buf_rdata(buf_rdata),
        .sdram_read(sdram_read),
        .sdram_addr(sdram_addr),
        .sdram_readdata(sdram_readdata),
        .sdram_finished(sdram_finished)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
        logic [15:0] k;
        if (a == cur_base) return clip_len;
        k = 16'(a - cur_base - ADDR_W'(1));
        return {k, ~k};
    endfunction

    // SDRAM model: completes a read lat cycles after it appears, checks
    // address stability and the idle cycle after each completion.
    initial begin : sdram_model
        int cnt;
        logic [ADDR_W-1:0] held;
        cnt = 0;
        held = '0;
        sdram_finished = 1'b0;
        sdram_readdata = '0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                sdram_finished = 1'b0;
                cnt = 0;
            end else if (sdram_finished) begin
                sdram_finished = 1'b0;
                cnt = 0;
                checkOutput("read_gap", 64'(sdram_read), 64'd0);
            end else if (sdram_read) begin
                if (cnt == 0) held = sdram_addr;
                else checkOutput("addr_stable", 64'(sdram_addr), 64'(held));
                cnt++;
                if (cnt >= lat) begin
                    sdram_finished = 1'b1;
                    sdram_readdata = word_at(sdram_addr);
                    if (sdram_addr == cur_base) hdr_cnt++;
                    else rd_cnt++;
                    if (!first_seen) begin
                        first_seen = 1'b1;
                        first_addr = sdram_addr;
                    end
                    if (sdram_addr > max_addr) max_addr = sdram_addr;
                end
            end
        end
    end

    // Consumer/monitor: on each valid frame, pop the expected frame, read the
    // buffer through buf_raddr, compare, then ack.
    initial begin : consumer
        frame_t exp;
        buf_raddr = '0;
        fetch_frame_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            if (fetch_frame_valid && !i_rst) begin
                checkOutput("frame_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) exp = exp_q.pop_front();
                else exp = '0;
                checkOutput($sformatf("frame%0d_last", frames_seen),
                            64'(fetch_last), 64'(exp.last));
                for (int k = 0; k < FRAME_SIZE; k++) begin
                    buf_raddr = AW'(k);
                    @(negedge i_clk);
                    checkOutput($sformatf("frame%0d_word%0d", frames_seen, k),
                                64'(buf_rdata), 64'(exp.words[k*32 +: 32]));
                end
                fetch_frame_ack = 1'b1;
                @(negedge i_clk);
                fetch_frame_ack = 1'b0;
                checkOutput("valid_fall", 64'(fetch_frame_valid), 64'd0);
                frames_seen++;
            end
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge i_clk);
            if (fetch_done) done_cnt++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [31:0] len,
                                 input logic [3:0] speed, input int latency);
        int sp, ha, idx;
        bit lastf;
        frame_t fr;
        sp = (speed == 4'd0) ? 1 : int'(speed);
        ha = (HS * sp) >> 3;
        if (ha == 0) ha = 1;
        if (len != 32'd0) begin
            lastf = 1'b0;
            for (int f = 0; !lastf && f < 64; f++) begin
                for (int k = 0; k < FRAME_SIZE; k++) begin
                    idx = f * ha + k;
                    fr.words[k*32 +: 32] = (idx < int'(len)) ?
                                           {16'(idx), ~16'(idx)} : 32'd0;
                end
                fr.last = (f * ha + FRAME_SIZE >= int'(len));
                lastf = fr.last;
                exp_q.push_back(fr);
            end
        end
        cur_base = base;
        clip_len = len;
        lat = latency;
        rd_cnt = 0;
        hdr_cnt = 0;
        frames_seen = 0;
        done_cnt = 0;
        first_seen = 1'b0;
        max_addr = '0;
        @(negedge i_clk);
        fetch_base = base;
        fetch_speed = speed;
        fetch_start = 1'b1;
        @(negedge i_clk);
        fetch_start = 1'b0;
    endtask

    task automatic runToDone(input int budget, input bit poke);
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < budget) begin
            @(negedge i_clk);
            cyc++;
            if (poke && cyc == 30) begin
                fetch_start = 1'b1;
                fetch_base = BASE_A;
                fetch_speed = 4'd8;
            end else begin
                fetch_start = 1'b0;
            end
        end
        fetch_start = 1'b0;
        checkOutput("done_in_budget", 64'(done_cnt != 0), 64'd1);
        repeat (4) @(negedge i_clk);
    endtask

    task automatic checkVector(input string tag, input logic [ADDR_W-1:0] base,
                               input logic [31:0] len, input int exp_frames,
                               input int reads_full, input int reads_overlap,
                               input logic [ADDR_W-1:0] exp_max);
        int exp_reads;
`ifdef PITCH_FETCH_OVERLAP_EN
        exp_reads = reads_overlap;
`else
        exp_reads = reads_full;
`endif
        checkOutput({tag, "_frames"}, 64'(frames_seen), 64'(exp_frames));
        checkOutput({tag, "_sample_reads"}, 64'(rd_cnt), 64'(exp_reads));
        checkOutput({tag, "_header_reads"}, 64'(hdr_cnt), 64'd1);
        checkOutput({tag, "_first_addr"}, 64'(first_addr), 64'(base));
        checkOutput({tag, "_max_addr"}, 64'(max_addr), 64'(exp_max));
        checkOutput({tag, "_length"}, 64'(fetch_length), 64'(len));
        checkOutput({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        checkOutput({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : main
        i_rst = 1'b1;
        fetch_start = 1'b0;
        fetch_base = '0;
        fetch_speed = '0;
        repeat (3) @(negedge i_clk);
        checkOutput("rst_sdram_read", 64'(sdram_read), 64'd0);
        checkOutput("rst_valid", 64'(fetch_frame_valid), 64'd0);
        checkOutput("rst_done", 64'(fetch_done), 64'd0);
        checkOutput("rst_length", 64'(fetch_length), 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        $display("[TB] speed 8, length 20");
        applyStimulus(BASE_A, 32'd20, 4'd8, 2);
        runToDone(2000, 1'b0);
        checkVector("len20", BASE_A, 32'd20, 4, 32, 20, BASE_A + 16'd20);

        $display("[TB] speed 8, length 10");
        applyStimulus(BASE_A, 32'd10, 4'd8, 2);
        runToDone(2000, 1'b0);
        checkVector("len10", BASE_A, 32'd10, 2, 14, 10, BASE_A + 16'd10);

        $display("[TB] length 0");
        applyStimulus(BASE_B, 32'd0, 4'd8, 2);
        runToDone(2000, 1'b0);
        checkVector("len0", BASE_B, 32'd0, 0, 0, 0, BASE_B);

        $display("[TB] speed 0, length 10");
        applyStimulus(BASE_A, 32'd10, 4'd0, 2);
        runToDone(2000, 1'b0);
        checkVector("speed0", BASE_A, 32'd10, 3, 24, 10, BASE_A + 16'd10);

        $display("[TB] speed 15, length 12, slow SDRAM, start poked mid-fill");
        applyStimulus(BASE_B, 32'd12, 4'd15, 5);
        runToDone(3000, 1'b1);
        checkVector("speed15", BASE_B, 32'd12, 2, 13, 12, BASE_B + 16'd12);

        $display("[TB] reset during fill");
        applyStimulus(BASE_A, 32'd20, 4'd8, 2);
        repeat (20) @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        checkOutput("midrst_sdram_read", 64'(sdram_read), 64'd0);
        checkOutput("midrst_sdram_addr", 64'(sdram_addr), 64'd0);
        checkOutput("midrst_length", 64'(fetch_length), 64'd0);
        checkOutput("midrst_valid", 64'(fetch_frame_valid), 64'd0);
        checkOutput("midrst_last", 64'(fetch_last), 64'd0);
        checkOutput("midrst_done", 64'(fetch_done), 64'd0);
        checkOutput("midrst_rdata", 64'(buf_rdata), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        exp_q.delete();
        @(negedge i_clk);
        applyStimulus(BASE_B, 32'd20, 4'd8, 2);
        runToDone(2000, 1'b0);
        checkVector("after_rst", BASE_B, 32'd20, 4, 32, 20, BASE_B + 16'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
